jtag_cfg_sched: RTL and testbench

CLK-domain scheduler that commits configuration words into a shared bank of NFUNC configuration registers feeding the DMB datapath. There are two requester types:
- JTAG user write registers, which raise a one-cycle update strobe with a held parallel word.
- A local slow-control write port with a req/ack handshake.

The block arbitrates between them, defers each commit while the datapath reports busy, and emits a per-function one-cycle apply strobe.

---
 rtl/jtag_cfg_pkg.sv | 21 ++
 rtl/jtag_cfg_sched_rr_pick.sv | 31 +++
 rtl/jtag_cfg_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_jtag_cfg_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_cfg_pkg.sv
// Shared types and helpers for the JTAG/local configuration commit scheduler.
package jtag_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    APPLY
  } cfg_state_t;

  typedef enum logic {
    JTAG,
    LOCAL
  } req_src_t;

  // Bit offset of bank entry idx when entries are W bits wide.
  function automatic int unsigned cfg_off(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/jtag_cfg_sched_rr_pick.sv
// Combinational NFUNC-way round-robin picker: first request at or after i_ptr wins.
module cfg_rr_pick #(
  parameter int NFUNC = 4,
  parameter int FW    = 2
) (
  input  logic [NFUNC-1:0] i_req,
  input  logic [FW-1:0]    i_ptr,
  output logic [NFUNC-1:0] o_gnt,
  output logic [FW-1:0]    o_idx,
  output logic             o_vld
);

  always_comb begin
    int unsigned w_ptr;
    int unsigned w_cand;
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_ptr  = 32'(i_ptr);
    w_cand = 0;
    for (int unsigned k = 0; k < NFUNC; k++) begin
      w_cand = (w_ptr + k) % NFUNC;
      if (!o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = FW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/jtag_cfg_sched.sv
// Commits JTAG-update and local-port configuration words into a shared bank,
// deferring while the datapath is busy, with optional triplicated storage.
module jtag_cfg_sched
  import jtag_cfg_pkg::*;
#(
  parameter int                  NFUNC     = 4,
  parameter int                  W         = 8,
  parameter int                  FW        = 2,
  parameter logic [NFUNC*W-1:0]  DEF_VALUE = '0,
  parameter int                  TMO       = 255,
  parameter int                  TMO_W     = 8,
  parameter int                  TMR       = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NFUNC-1:0]     UPD_STB,
  input  logic [NFUNC*W-1:0]   JTAG_PO,
  input  logic                 LCL_REQ,
  input  logic [FW-1:0]        LCL_FUNC,
  input  logic [W-1:0]         LCL_DATA,
  output logic                 LCL_ACK,
  input  logic                 BUSY_IN,
  input  logic                 CLR_ERR,
  output logic [NFUNC*W-1:0]   CFG_OUT,
  output logic [NFUNC-1:0]     CFG_STB,
  output logic [NFUNC-1:0]     PEND,
  output logic                 TMO_ERR
);

  cfg_state_t         r_state;
  cfg_state_t         w_state_nxt;
  req_src_t           r_last;
  req_src_t           r_gnt_src;
  logic [FW-1:0]      r_ptr;
  logic [NFUNC-1:0]   r_pend;
  logic [NFUNC-1:0]   r_gnt_oh;
  logic [NFUNC-1:0]   r_stb;
  logic [W-1:0]       r_data;
  logic [TMO_W-1:0]   r_cnt;
  logic               r_ack;
  logic               r_tmo_err;

  logic [NFUNC-1:0]   w_rr_gnt;
  logic [FW-1:0]      w_rr_idx;
  logic               w_rr_vld;
  logic [FW-1:0]      w_ptr_nxt;
  logic               w_take_local;
  logic               w_tmo_hit;
  logic [NFUNC-1:0]   w_lcl_oh;
  logic [NFUNC-1:0]   w_pend_clr;
  logic [W-1:0]       w_jtag_word;
  logic [NFUNC*W-1:0] w_bank_q;
  logic [NFUNC*W-1:0] w_bank_d;

  cfg_rr_pick #(
    .NFUNC (NFUNC),
    .FW    (FW)
  ) u_rr_pick (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_vld (w_rr_vld)
  );

  always_comb begin
    int unsigned w_nxt;
    w_nxt     = (32'(w_rr_idx) + 1) % NFUNC;
    w_ptr_nxt = FW'(w_nxt);
  end

  // Out-of-range local targets decode to an all-zero one-hot: acked, never written.
  always_comb begin
    w_lcl_oh = '0;
    for (int unsigned i = 0; i < NFUNC; i++) begin
      w_lcl_oh[i] = (32'(LCL_FUNC) == i);
    end
  end

  always_comb begin
    w_jtag_word = '0;
    for (int unsigned i = 0; i < NFUNC; i++) begin
      if (r_gnt_oh[i]) begin
        w_jtag_word = w_jtag_word | JTAG_PO[cfg_off(i, W) +: W];
      end
    end
  end

  assign w_pend_clr = (r_state == APPLY && r_gnt_src == JTAG) ? r_gnt_oh : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_take_local = 1'b0;
    w_tmo_hit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rr_vld || LCL_REQ) begin
          w_state_nxt  = GRANT;
          w_take_local = LCL_REQ && !(r_last == LOCAL && w_rr_vld);
        end
      end
      GRANT: begin
        w_state_nxt = BUSY_IN ? WAIT : APPLY;
      end
      WAIT: begin
        if (!BUSY_IN) begin
          w_state_nxt = APPLY;
        end else if ((TMO != 0) && (int'(r_cnt) == TMO - 1)) begin
          w_state_nxt = APPLY;
          w_tmo_hit   = 1'b1;
        end
      end
      APPLY: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_last    <= JTAG;
      r_gnt_src <= JTAG;
      r_ptr     <= '0;
      r_pend    <= '0;
      r_gnt_oh  <= '0;
      r_stb     <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~w_pend_clr) | UPD_STB;
      r_stb   <= '0;
      r_ack   <= 1'b0;
      if (r_state == IDLE && w_state_nxt == GRANT) begin
        if (w_take_local) begin
          r_gnt_src <= LOCAL;
          r_last    <= LOCAL;
          r_gnt_oh  <= w_lcl_oh;
        end else begin
          r_gnt_src <= JTAG;
          r_last    <= JTAG;
          r_gnt_oh  <= w_rr_gnt;
          r_ptr     <= w_ptr_nxt;
        end
      end
      if (r_state == GRANT) begin
        r_data <= (r_gnt_src == LOCAL) ? LCL_DATA : w_jtag_word;
        r_cnt  <= '0;
      end
      if (r_state == WAIT) begin
        r_cnt <= r_cnt + TMO_W'(1);
      end
      if (r_state == APPLY) begin
        r_stb <= r_gnt_oh;
        r_ack <= (r_gnt_src == LOCAL);
      end
      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
      end else if (CLR_ERR) begin
        r_tmo_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_bank_d = w_bank_q;
    if (r_state == APPLY) begin
      for (int unsigned i = 0; i < NFUNC; i++) begin
        if (r_gnt_oh[i]) begin
          w_bank_d[cfg_off(i, W) +: W] = r_data;
        end
      end
    end
  end

  // Every copy reloads from the voted value each cycle, so a single upset heals.
  if (TMR != 0) begin : g_tmr
    logic [NFUNC*W-1:0] r_cp0;
    logic [NFUNC*W-1:0] r_cp1;
    logic [NFUNC*W-1:0] r_cp2;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cp0 <= DEF_VALUE;
        r_cp1 <= DEF_VALUE;
        r_cp2 <= DEF_VALUE;
      end else begin
        r_cp0 <= w_bank_d;
        r_cp1 <= w_bank_d;
        r_cp2 <= w_bank_d;
      end
    end

    assign w_bank_q = (r_cp0 & r_cp1) | (r_cp0 & r_cp2) | (r_cp1 & r_cp2);
  end else begin : g_plain
    logic [NFUNC*W-1:0] r_cp0;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cp0 <= DEF_VALUE;
      end else begin
        r_cp0 <= w_bank_d;
      end
    end

    assign w_bank_q = r_cp0;
  end

  assign CFG_OUT = w_bank_q;
  assign CFG_STB = r_stb;
  assign PEND    = r_pend;
  assign LCL_ACK = r_ack;
  assign TMO_ERR = r_tmo_err;

endmodule

// File: tb/tb_jtag_cfg_sched.sv
// Directed bench for jtag_cfg_sched: drives a TMR and a plain instance in lockstep.
module tb_jtag_cfg_sched;

  localparam int          NFUNC = 4;
  localparam int          W     = 8;
  localparam int          FW    = 3;
  localparam int          TMO   = 16;
  localparam logic [31:0] DEF   = 32'h4433_2211;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  UPD_STB;
  logic [31:0] JTAG_PO;
  logic        LCL_REQ;
  logic [2:0]  LCL_FUNC;
  logic [7:0]  LCL_DATA;
  logic        BUSY_IN;
  logic        CLR_ERR;

  logic        ack_t, err_t, ack_p, err_p;
  logic [31:0] cfg_t, cfg_p;
  logic [3:0]  stb_t, pend_t, stb_p, pend_p;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cfg;
  logic [3:0]  oh_seq [3];
  logic [3:0]  pend_seq [3];
  logic [31:0] cfg_seq [3];

  always #5 CLK = ~CLK;

  jtag_cfg_sched #(
    .NFUNC(NFUNC), .W(W), .FW(FW), .DEF_VALUE(DEF), .TMO(TMO), .TMO_W(8), .TMR(1)
  ) u_dut (
    .CLK(CLK), .RST(RST), .UPD_STB(UPD_STB), .JTAG_PO(JTAG_PO),
    .LCL_REQ(LCL_REQ), .LCL_FUNC(LCL_FUNC), .LCL_DATA(LCL_DATA), .LCL_ACK(ack_t),
    .BUSY_IN(BUSY_IN), .CLR_ERR(CLR_ERR), .CFG_OUT(cfg_t), .CFG_STB(stb_t),
    .PEND(pend_t), .TMO_ERR(err_t)
  );

  jtag_cfg_sched #(
    .NFUNC(NFUNC), .W(W), .FW(FW), .DEF_VALUE(DEF), .TMO(TMO), .TMO_W(8), .TMR(0)
  ) u_dut_plain (
    .CLK(CLK), .RST(RST), .UPD_STB(UPD_STB), .JTAG_PO(JTAG_PO),
    .LCL_REQ(LCL_REQ), .LCL_FUNC(LCL_FUNC), .LCL_DATA(LCL_DATA), .LCL_ACK(ack_p),
    .BUSY_IN(BUSY_IN), .CLR_ERR(CLR_ERR), .CFG_OUT(cfg_p), .CFG_STB(stb_p),
    .PEND(pend_p), .TMO_ERR(err_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_cfg, input logic [3:0] e_stb,
                         input logic [3:0] e_pend, input logic e_ack, input logic e_err);
    chk({tag, ".tmr.cfg"},  cfg_t,         e_cfg);
    chk({tag, ".tmr.stb"},  32'(stb_t),    32'(e_stb));
    chk({tag, ".tmr.pend"}, 32'(pend_t),   32'(e_pend));
    chk({tag, ".tmr.ack"},  32'(ack_t),    32'(e_ack));
    chk({tag, ".tmr.err"},  32'(err_t),    32'(e_err));
    chk({tag, ".pln.cfg"},  cfg_p,         e_cfg);
    chk({tag, ".pln.stb"},  32'(stb_p),    32'(e_stb));
    chk({tag, ".pln.pend"}, 32'(pend_p),   32'(e_pend));
    chk({tag, ".pln.ack"},  32'(ack_p),    32'(e_ack));
    chk({tag, ".pln.err"},  32'(err_p),    32'(e_err));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; UPD_STB = '0; JTAG_PO = '0; LCL_REQ = 1'b0; LCL_FUNC = '0;
    LCL_DATA = '0; BUSY_IN = 1'b0; CLR_ERR = 1'b0;

    // Reset state
    step(); step();
    chk_all("rst", DEF, 4'b0000, 4'b0000, 1'b0, 1'b0);
    RST = 1'b0;
    step();
    chk_all("idle", DEF, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Single JTAG update, three-edge latency, snapshot at GRANT
    UPD_STB = 4'b0100; JTAG_PO = 32'h00A5_0000;
    step(); chk_all("t1.e0", DEF, 4'b0000, 4'b0100, 1'b0, 1'b0);
    UPD_STB = '0;
    step(); chk_all("t1.e1", DEF, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(); chk_all("t1.e2", DEF, 4'b0000, 4'b0100, 1'b0, 1'b0);
    JTAG_PO = 32'h00FF_0000;
    step(); chk_all("t1.e3", 32'h44A5_2211, 4'b0100, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t1.e4", 32'h44A5_2211, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Simultaneous strobes commit 0,1,3 in round-robin order
    do_reset();
    JTAG_PO = 32'hD3FF_B1B0; UPD_STB = 4'b1011;
    step(); chk_all("t2.e0", DEF, 4'b0000, 4'b1011, 1'b0, 1'b0);
    UPD_STB = '0;
    oh_seq   = '{4'b0001, 4'b0010, 4'b1000};
    pend_seq = '{4'b1010, 4'b1000, 4'b0000};
    cfg_seq  = '{32'h4433_22B0, 32'h4433_B1B0, 32'hD333_B1B0};
    exp_cfg = DEF;
    for (int k = 0; k < 3; k++) begin
      step(); chk_all($sformatf("t2.c%0d.a", k), exp_cfg, 4'b0000, (k == 0) ? 4'b1011 : pend_seq[k-1], 1'b0, 1'b0);
      step(); chk_all($sformatf("t2.c%0d.b", k), exp_cfg, 4'b0000, (k == 0) ? 4'b1011 : pend_seq[k-1], 1'b0, 1'b0);
      step(); exp_cfg = cfg_seq[k];
      chk_all($sformatf("t2.c%0d.apply", k), exp_cfg, oh_seq[k], pend_seq[k], 1'b0, 1'b0);
    end

    // Local vs JTAG contention and alternation
    do_reset();
    LCL_REQ = 1'b1; LCL_FUNC = 3'd1; LCL_DATA = 8'h3C; UPD_STB = 4'b0001; JTAG_PO = 32'h0000_005A;
    step(); chk_all("t3.e0", DEF, 4'b0000, 4'b0001, 1'b0, 1'b0);
    UPD_STB = '0;
    step(); chk_all("t3.e1", DEF, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step(); chk_all("t3.e2", 32'h4433_3C11, 4'b0010, 4'b0001, 1'b1, 1'b0);
    LCL_FUNC = 3'd3; LCL_DATA = 8'h77;
    step(); chk_all("t3.e3", 32'h4433_3C11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step(); chk_all("t3.e4", 32'h4433_3C11, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step(); chk_all("t3.e5", 32'h4433_3C5A, 4'b0001, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t3.e6", 32'h4433_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t3.e7", 32'h4433_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t3.e8", 32'h7733_3C5A, 4'b1000, 4'b0000, 1'b1, 1'b0);
    LCL_REQ = 1'b0;
    step(); chk_all("t3.e9", 32'h7733_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Busy deferral shorter than the timeout
    BUSY_IN = 1'b1; LCL_REQ = 1'b1; LCL_FUNC = 3'd2; LCL_DATA = 8'hE2;
    for (int k = 0; k < 11; k++) begin
      step(); chk_all($sformatf("t4.busy%0d", k), 32'h7733_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    BUSY_IN = 1'b0;
    step(); chk_all("t4.e11", 32'h7733_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t4.e12", 32'h77E2_3C5A, 4'b0100, 4'b0000, 1'b1, 1'b0);
    LCL_REQ = 1'b0;

    // Forced commit after 16 WAIT cycles, sticky error until cleared
    BUSY_IN = 1'b1; LCL_REQ = 1'b1; LCL_FUNC = 3'd0; LCL_DATA = 8'hC0;
    for (int k = 0; k < 17; k++) begin
      step(); chk_all($sformatf("t5.wait%0d", k), 32'h77E2_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    step(); chk_all("t5.e17", 32'h77E2_3C5A, 4'b0000, 4'b0000, 1'b0, 1'b1);
    step(); chk_all("t5.e18", 32'h77E2_3CC0, 4'b0001, 4'b0000, 1'b1, 1'b1);
    LCL_REQ = 1'b0; BUSY_IN = 1'b0;
    step(); chk_all("t5.sticky", 32'h77E2_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    CLR_ERR = 1'b1;
    step(); chk_all("t5.clr", 32'h77E2_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Timeout with CLR_ERR held: setting wins on the timeout edge
    BUSY_IN = 1'b1; LCL_REQ = 1'b1; LCL_FUNC = 3'd3; LCL_DATA = 8'h3E;
    for (int k = 0; k < 17; k++) begin
      step(); chk_all($sformatf("t5b.wait%0d", k), 32'h77E2_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    step(); chk_all("t5b.e17", 32'h77E2_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    step(); chk_all("t5b.e18", 32'h3EE2_3CC0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    LCL_REQ = 1'b0; BUSY_IN = 1'b0; CLR_ERR = 1'b0;

    // Re-strobe during APPLY forces a second commit
    JTAG_PO = 32'h0011_0000; UPD_STB = 4'b0100;
    step(); chk_all("t6.e0", 32'h3EE2_3CC0, 4'b0000, 4'b0100, 1'b0, 1'b0);
    UPD_STB = '0;
    step(); chk_all("t6.e1", 32'h3EE2_3CC0, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(); chk_all("t6.e2", 32'h3EE2_3CC0, 4'b0000, 4'b0100, 1'b0, 1'b0);
    UPD_STB = 4'b0100; JTAG_PO = 32'h0022_0000;
    step(); chk_all("t6.e3", 32'h3E11_3CC0, 4'b0100, 4'b0100, 1'b0, 1'b0);
    UPD_STB = '0;
    step(); chk_all("t6.e4", 32'h3E11_3CC0, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(); chk_all("t6.e5", 32'h3E11_3CC0, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(); chk_all("t6.e6", 32'h3E22_3CC0, 4'b0100, 4'b0000, 1'b0, 1'b0);

    // Local target out of range: ack only
    LCL_REQ = 1'b1; LCL_FUNC = 3'd5; LCL_DATA = 8'hEE;
    step(); chk_all("t7.e0", 32'h3E22_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t7.e1", 32'h3E22_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(); chk_all("t7.e2", 32'h3E22_3CC0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    LCL_REQ = 1'b0;
    step(); chk_all("t7.e3", 32'h3E22_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset while waiting on busy
    BUSY_IN = 1'b1; LCL_REQ = 1'b1; LCL_FUNC = 3'd1; LCL_DATA = 8'h99;
    step(); step(); step();
    chk_all("t8.wait", 32'h3E22_3CC0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    RST = 1'b1; LCL_REQ = 1'b0; BUSY_IN = 1'b0;
    #1; chk_all("t8.async", DEF, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(); RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk_all($sformatf("t8.post%0d", k), DEF, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end

    // Single-copy upset is outvoted and repaired
    @(negedge CLK);
    force u_dut.g_tmr.r_cp1 = DEF ^ 32'h0000_0400;
    #1;
    chk("t9.flip", u_dut.g_tmr.r_cp1, 32'h4433_2611);
    chk("t9.vote", cfg_t, DEF);
    release u_dut.g_tmr.r_cp1;
    step();
    chk("t9.repair", u_dut.g_tmr.r_cp1, DEF);
    chk("t9.vote2", cfg_t, DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
